nes_cpu_bus: RTL and testbench

NES_CPU_BUS -- requirements
Module: nes_cpu_bus

---
 rtl/nes_bus_pkg.sv | 41 ++++
 rtl/nes_cpu_bus_if.sv | 23 ++
 rtl/nes_oam_dma.sv | 80 ++++++++
 rtl/nes_cpu_bus.sv | 111 +++++++++++
 tb/tb_nes_cpu_bus.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/nes_bus_pkg.sv
// Shared types and constants for the NES CPU bus slice.
//   dma_state_e : OAM DMA sequencer states
//   region_e    : CPU address decode result
//   Region base/limit constants and the trap addresses used by the optional
//   simulation trap logic.
//   decode_region() maps a 16-bit CPU address to its region.
package nes_bus_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDummy,
    StAlign,
    StRd,
    StWr
  } dma_state_e;

  typedef enum logic [1:0] {
    RegionRam,
    RegionRom,
    RegionNone
  } region_e;

  localparam logic [15:0] RamBase       = 16'h0000;
  localparam logic [15:0] RamLimit      = 16'h1FFF;
  localparam logic [15:0] RomBase       = 16'h8000;
  localparam logic [15:0] RomLimit      = 16'hFFFF;
  localparam logic [15:0] TrapDoneAddr  = 16'hFFFF;
  localparam logic [15:0] TrapErrorAddr = 16'hFFFE;

  // RamBase is zero and RomLimit is the top of the map, so only one bound
  // of each window needs an actual comparison.
  function automatic region_e decode_region(input logic [15:0] addr);
    if (addr <= RamLimit) begin
      return RegionRam;
    end else if (addr >= RomBase) begin
      return RegionRom;
    end
    return RegionNone;
  endfunction

endpackage

// File: rtl/nes_cpu_bus_if.sv
// CPU-side bus handshake between the 6502 core and nes_cpu_bus.
//   i_addr : CPU address
//   i_rw   : 1 = CPU write, 0 = CPU read
//   o_rdy  : CPU ready, low while OAM DMA owns the bus
// The bidirectional data bus stays a plain inout port on the top so that the
// tristate resolution lives on a single net outside the interface.
interface nes_cpu_bus_if;
  logic [15:0] i_addr;
  logic        i_rw;
  logic        o_rdy;

  modport master (
    output i_addr,
    output i_rw,
    input  o_rdy
  );

  modport slave (
    input  i_addr,
    input  i_rw,
    output o_rdy
  );
endinterface

// File: rtl/nes_oam_dma.sv
// OAM DMA sequencer: after a start pulse it copies page {P, 00..FF} into OAM,
// one byte per read/write cycle pair.
//   i_clk, i_rst          : clock, asynchronous active-high reset
//   i_start, i_page       : start pulse and source page P (sampled in idle)
//   i_rd_data             : byte read at o_src_addr through the top's decode
//   o_rdy                 : high only in idle; low halts the CPU
//   o_src_addr            : {P, idx} source address for the read cycle
//   o_oam_we/addr/data    : OAM write port
module nes_oam_dma (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [7:0]  i_page,
  input  logic [7:0]  i_rd_data,
  output logic        o_rdy,
  output logic [15:0] o_src_addr,
  output logic        o_oam_we,
  output logic [7:0]  o_oam_addr,
  output logic [7:0]  o_oam_data
);
  import nes_bus_pkg::*;

  dma_state_e state_q, state_d;
  logic       parity_q;
  logic [7:0] idx_q, idx_d;
  logic [7:0] page_q, page_d;
  logic [7:0] data_q, data_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= StIdle;
      parity_q <= 1'b0;
      idx_q    <= 8'h00;
      page_q   <= 8'h00;
      data_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      parity_q <= ~parity_q;
      idx_q    <= idx_d;
      page_q   <= page_d;
      data_q   <= data_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    page_d   = page_q;
    data_d   = data_q;
    o_oam_we = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d = StDummy;
          page_d  = i_page;
        end
      end
      // Parity 1 in the dummy cycle means the next cycle is already even, so
      // reads land on parity 0 directly; otherwise burn one alignment cycle.
      StDummy: state_d = parity_q ? StRd : StAlign;
      StAlign: state_d = StRd;
      StRd: begin
        data_d  = i_rd_data;
        state_d = StWr;
      end
      StWr: begin
        o_oam_we = 1'b1;
        idx_d    = idx_q + 8'd1;
        state_d  = (idx_q == 8'hFF) ? StIdle : StRd;
      end
      default: state_d = StIdle;
    endcase
  end

  assign o_rdy      = (state_q == StIdle);
  assign o_src_addr = {page_q, idx_q};
  assign o_oam_addr = idx_q;
  assign o_oam_data = data_q;

endmodule

// File: rtl/nes_cpu_bus.sv
// NES CPU bus: address decode, mirrored work RAM, PRG ROM port, open-bus
// latch, OAM DMA and optional simulation traps.
//   i_clk, i_rst        : clock, asynchronous active-high reset
//   bus (slave)         : CPU address, direction and ready
//   io_data             : CPU data bus, driven only during CPU reads
//   o_rom_addr/i_rom_data : asynchronous PRG ROM port
//   o_oam_we/addr/data  : OAM write port
//   o_sim_done/o_sim_error : sticky trap flags
// Define NES_BUS_SIM_TRAP_EN to enable the traps: writes to 0xFFFF/0xFFFE set
// o_sim_done/o_sim_error. Without it both flags are tied low.
// RAM_BYTES must be a power of two; the mirror is formed by dropping the
// upper address bits.
module nes_cpu_bus #(
  parameter int unsigned RAM_BYTES = 2048,
  parameter logic [15:0] DMA_REG   = 16'h4014
) (
  input  logic        i_clk,
  input  logic        i_rst,
  nes_cpu_bus_if.slave bus,
  inout  wire  [7:0]  io_data,
  output logic [14:0] o_rom_addr,
  input  logic [7:0]  i_rom_data,
  output logic        o_oam_we,
  output logic [7:0]  o_oam_addr,
  output logic [7:0]  o_oam_data,
  output logic        o_sim_done,
  output logic        o_sim_error
);
  import nes_bus_pkg::*;

  localparam int unsigned RamAw = $clog2(RAM_BYTES);

  logic        rdy;
  logic        cpu_rd, cpu_wr, dma_start;
  logic [15:0] dma_src, eff_addr;
  region_e     region;
  logic [7:0]  rd_data, open_bus_q;
  logic [7:0]  ram [RAM_BYTES];

  assign bus.o_rdy = rdy;
  // CPU inputs count only while the CPU owns the bus.
  assign cpu_rd    = rdy & ~bus.i_rw;
  assign cpu_wr    = rdy & bus.i_rw;
  assign dma_start = cpu_wr && (bus.i_addr == DMA_REG);

  // One read path shared by the CPU and the DMA source reads.
  assign eff_addr   = rdy ? bus.i_addr : dma_src;
  assign region     = decode_region(eff_addr);
  assign o_rom_addr = eff_addr[14:0];

  always_comb begin
    rd_data = open_bus_q;
    unique case (region)
      RegionRam: rd_data = ram[eff_addr[RamAw-1:0]];
      RegionRom: rd_data = i_rom_data;
      default:   rd_data = open_bus_q;
    endcase
  end

  assign io_data = cpu_rd ? rd_data : 8'hzz;

  // Work RAM keeps its contents across reset.
  always_ff @(posedge i_clk) begin
    if (cpu_wr && (region == RegionRam)) begin
      ram[eff_addr[RamAw-1:0]] <= io_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      open_bus_q <= 8'h00;
    end else if (cpu_wr) begin
      open_bus_q <= io_data;
    end else if (cpu_rd) begin
      open_bus_q <= rd_data;
    end
  end

`ifdef NES_BUS_SIM_TRAP_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_sim_done  <= 1'b0;
      o_sim_error <= 1'b0;
    end else begin
      if (cpu_wr && (bus.i_addr == TrapDoneAddr)) begin
        o_sim_done <= 1'b1;
      end
      if (cpu_wr && (bus.i_addr == TrapErrorAddr)) begin
        o_sim_error <= 1'b1;
      end
    end
  end
`else
  assign o_sim_done  = 1'b0;
  assign o_sim_error = 1'b0;
`endif

  nes_oam_dma u_dma (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (dma_start),
    .i_page     (io_data),
    .i_rd_data  (rd_data),
    .o_rdy      (rdy),
    .o_src_addr (dma_src),
    .o_oam_we   (o_oam_we),
    .o_oam_addr (o_oam_addr),
    .o_oam_data (o_oam_data)
  );

endmodule

// File: tb/tb_nes_cpu_bus.sv
// Directed bench for nes_cpu_bus: RAM mirroring, ROM port, open bus, OAM DMA
// length/content on both parities, DMA abort by reset, and trap flags.
module tb_nes_cpu_bus;

  logic        clk;
  logic        rst;
  logic        drv;
  logic [7:0]  wdata;
  wire  [7:0]  io_data;
  logic [14:0] rom_addr;
  logic [7:0]  rom_data;
  logic        oam_we;
  logic [7:0]  oam_addr, oam_data;
  logic        sim_done, sim_error;

  int tests = 0;
  int fails = 0;
  int edges;

  nes_cpu_bus_if bus ();

  nes_cpu_bus dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .bus         (bus),
    .io_data     (io_data),
    .o_rom_addr  (rom_addr),
    .i_rom_data  (rom_data),
    .o_oam_we    (oam_we),
    .o_oam_addr  (oam_addr),
    .o_oam_data  (oam_data),
    .o_sim_done  (sim_done),
    .o_sim_error (sim_error)
  );

  assign io_data  = drv ? wdata : 8'hzz;
  // ROM returns the low byte of its address.
  assign rom_data = rom_addr[7:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Parity model: flop starts at 0 and toggles on every edge out of reset.
  always @(posedge clk or posedge rst) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    bus.i_addr = a;
    bus.i_rw   = 1'b1;
    drv        = 1'b1;
    wdata      = d;
    @(posedge clk); #1;
    bus.i_rw   = 1'b0;
    drv        = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] a, input logic [7:0] exp, input string tag);
    bus.i_addr = a;
    bus.i_rw   = 1'b0;
    drv        = 1'b0;
    #1;
    check(tag, {24'h0, io_data}, {24'h0, exp});
    @(posedge clk); #1;
  endtask

  task automatic wait_parity(input bit p);
    if (edges[0] != p) begin
      @(posedge clk); #1;
    end
  endtask

  // Starts a DMA from page 02 and counts halted cycles and OAM writes.
  task automatic run_dma(input int exp_low, input bit poke, input string tag);
    int low, writes, bad;
    low = 0; writes = 0; bad = 0;
    cpu_write(16'h4014, 8'h02);
    bus.i_addr = 16'h0000;
    for (int c = 0; c < 700; c++) begin
      if (bus.o_rdy) break;
      low++;
      if (poke && low == 5) begin
        bus.i_addr = 16'h4014; bus.i_rw = 1'b1; drv = 1'b1; wdata = 8'h03;
      end else begin
        bus.i_addr = 16'h0000; bus.i_rw = 1'b0; drv = 1'b0;
      end
      if (oam_we) begin
        if (oam_addr !== writes[7:0] || oam_data !== writes[7:0]) bad++;
        writes++;
      end
      @(posedge clk); #1;
    end
    check({tag, "_low_cycles"}, low, exp_low);
    check({tag, "_writes"}, writes, 256);
    check({tag, "_bad_data"}, bad, 0);
  endtask

  initial begin
    int writes;
    bit trap_en;
`ifdef NES_BUS_SIM_TRAP_EN
    trap_en = 1'b1;
`else
    trap_en = 1'b0;
`endif
    rst = 1'b1; drv = 1'b0; wdata = 8'h00;
    bus.i_addr = 16'h0000; bus.i_rw = 1'b0;
    #2;
    check("rst_rdy", {31'h0, bus.o_rdy}, 1);
    check("rst_oam_we", {31'h0, oam_we}, 0);
    check("rst_oam_addr", {24'h0, oam_addr}, 0);
    check("rst_oam_data", {24'h0, oam_data}, 0);
    check("rst_sim_done", {31'h0, sim_done}, 0);
    check("rst_sim_error", {31'h0, sim_error}, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    cpu_read(16'h5000, 8'h00, "open_bus_reset");

    cpu_write(16'h0002, 8'hA5);
    cpu_read(16'h0802, 8'hA5, "ram_mirror_0802");
    cpu_read(16'h1802, 8'hA5, "ram_mirror_1802");
    cpu_read(16'h0002, 8'hA5, "ram_0002");

    bus.i_addr = 16'hC012; bus.i_rw = 1'b0; #1;
    check("rom_addr", {17'h0, rom_addr}, 32'h4012);
    check("rom_data", {24'h0, io_data}, 32'h12);
    @(posedge clk); #1;

    cpu_write(16'h4000, 8'h5A);
    cpu_read(16'h5000, 8'h5A, "open_bus_write");

    cpu_write(16'hFFFE, 8'h00);
    check("trap_error", {31'h0, sim_error}, {31'h0, trap_en});
    check("trap_done_clear", {31'h0, sim_done}, 0);
    cpu_write(16'hFFFF, 8'h00);
    check("trap_done", {31'h0, sim_done}, {31'h0, trap_en});

    for (int i = 0; i < 256; i++) cpu_write(16'(16'h0200 + i), i[7:0]);

    wait_parity(1'b0);
    run_dma(513, 1'b0, "dma_even");
    wait_parity(1'b1);
    run_dma(514, 1'b1, "dma_odd");

    // Abort: reset after the 40th OAM write has committed.
    cpu_write(16'h4014, 8'h02);
    writes = 0;
    for (int c = 0; c < 200 && writes < 40; c++) begin
      if (oam_we) writes++;
      @(posedge clk); #1;
    end
    check("abort_writes_before", writes, 40);
    rst = 1'b1; #1;
    check("abort_rdy", {31'h0, bus.o_rdy}, 1);
    check("abort_oam_we", {31'h0, oam_we}, 0);
    check("abort_sim_done", {31'h0, sim_done}, 0);
    check("abort_sim_error", {31'h0, sim_error}, 0);
    @(negedge clk); rst = 1'b0;
    writes = 0;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      if (oam_we) writes++;
    end
    check("abort_writes_after", writes, 0);
    check("abort_rdy_after", {31'h0, bus.o_rdy}, 1);

    cpu_read(16'h0205, 8'h05, "ram_kept_0205");
    cpu_read(16'h0002, 8'hA5, "ram_kept_0002");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
